// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - handshaked sequential ALU, iterative one-bit-per-cycle shifts
// Optional build macro: ALU_SAT_EN (ADD/SUB saturate instead of wrapping)
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;       // operand A, doubles as the shift working value
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;       // remaining shift steps
  logic             sh_carry;  // last bit shifted out so far

  logic [CW-1:0]    k;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] ex_result;
  logic             ex_carry;
  logic             ex_overflow;

  // Effective shift count: shifting by WIDTH or more clears the value anyway
  always_comb begin
    k = '0;
    if (32'(b) >= WIDTH) k = CW'(WIDTH);
    else                 k = CW'(b);
  end

  // Single-cycle result and flags for every non-shift op
  always_comb begin
    sum         = {1'b0, a_q} + {1'b0, b_q};
    diff        = {1'b0, a_q} - {1'b0, b_q};
    ex_result   = '0;
    ex_carry    = 1'b0;
    ex_overflow = 1'b0;
    case (op_q)
      OP_AND: ex_result = a_q & b_q;
      OP_OR:  ex_result = a_q | b_q;
      OP_XOR: ex_result = a_q ^ b_q;
      OP_NOT: ex_result = ~a_q;
      OP_ADD: begin
        ex_carry    = sum[WIDTH];
        ex_overflow = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
`ifdef ALU_SAT_EN
        ex_result   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        ex_result   = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        ex_carry    = diff[WIDTH];
        ex_overflow = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
`ifdef ALU_SAT_EN
        ex_result   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        ex_result   = diff[WIDTH-1:0];
`endif
      end
      default: ex_result = '0;
    endcase
  end

  // Control FSM with registered handshake outputs, result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      sh_carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            a_q       <= a;
            b_q       <= b;
            op_q      <= opcode;
            sh_carry  <= 1'b0;
            req_ready <= 1'b0;
            if (opcode == OP_SHL || opcode == OP_SHR) begin
              cnt   <= k;
              state <= SHIFT;
            end else begin
              cnt   <= '0;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          result    <= ex_result;
          carry     <= ex_carry;
          overflow  <= ex_overflow;
          zero      <= (ex_result == '0);
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        SHIFT: begin
          if (cnt == '0) begin
            result    <= a_q;
            carry     <= sh_carry;
            overflow  <= 1'b0;
            zero      <= (a_q == '0);
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (op_q == OP_SHL) begin
              a_q      <= {a_q[WIDTH-2:0], 1'b0};
              sh_carry <= a_q[MSB];
            end else begin
              a_q      <= {1'b0, a_q[WIDTH-1:1]};
              sh_carry <= a_q[0];
            end
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
